cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
- Control unit for the 9-bit multicycle CPU. It is the driving end of the datapath bus: each cycle it issues the 10-bit one-hot bus select consumed by the bus multiplexer, plus the register, A, G and IR load enables.
- It holds the instruction register and sequences each instruction over 2 or 4 time steps (T0..T3), pulsing done on completion.

Parameters:
- DW, 9, datapath/instruction width (fixed 9 for this ISA).
- SEL_W, 10, bus select width (DIN, G, R0..R7).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- run  in  1  start request; sampled only in T0.
- din  in  9  external data/instruction word, format III_XXX_YYY (op[8:6], rx[5:3], ry[2:0]).
- bus_sel  out  10  one-hot select. Bit0=DIN, bit1=G, bit2..9=R0..R7.
- rin  out  8  register load enables; bit n loads Rn from the bus.
- ain  out  1  load A from the bus.
- gin  out  1  load G from the ALU.
- add_sub  out  1  ALU op: 0=add, 1=sub (A op bus).
- irin  out  1  IR load strobe (status/debug).
- ir  out  9  current instruction register.
- done  out  1  one-cycle completion pulse.

Behaviour:
- State register T0/T1/T2/T3, encoded in 2 bits. IR register is 9 bits.
- All outputs other than ir are combinational from state and IR. ir is registered.
- Default every cycle: bus_sel=10'b0000000001 (DIN), rin=0, ain=gin=add_sub=irin=done=0.
- Reset (rst=1 at a clk edge): state<=T0, ir<=0. Outputs settle to the defaults above.
- Reset mid-instruction aborts immediately. No further enables are issued for that instruction. Loads already performed in earlier cycles stand.
- Opcodes: 000 mv Rx<-Ry; 001 mvi Rx<-DIN (immediate word); 010 add Rx<-Rx+Ry; 011 sub Rx<-Rx-Ry; 100..111 reserved.
- T0: irin=run.
  - run=1: ir<=din, go to T1.
  - run=0: stay in T0.
- T1, by op:
  - mv: bus_sel=one-hot(Ry), i.e. bit 2+ry. rin[rx]=1, done=1, go to T0.
  - mvi: bus_sel=DIN code. rin[rx]=1, done=1, go to T0. The immediate must be on din during this cycle.
  - add/sub: bus_sel=one-hot(Rx), ain=1, go to T2.
  - reserved: no enables, done=1, go to T0 (executes as a NOP).
- T2 (add/sub only): bus_sel=one-hot(Ry), gin=1, add_sub=(op==011), go to T3.
- T3: bus_sel=G code (10'b0000000010), rin[rx]=1, done=1, go to T0.
- Latency from the T0 edge that loads IR:
  - mv/mvi/reserved: done in the next cycle; 2 cycles total.
  - add/sub: done in the 3rd cycle after T0; 4 cycles total.
- run is ignored in T1..T3. Holding run high issues back-to-back instructions with no idle cycle: the next T0 follows the done cycle.
- Invariants, checked every cycle:
  - bus_sel has exactly one bit set.
  - rin has at most one bit set.
  - ain, gin and rin are never active in the same cycle.
  - rx==ry is legal: e.g. add R3,R3 reads R3 in T1 and T2 and writes R3 in T3.
- No states other than T0..T3 are reachable. Any illegal encoding must return to T0 on the next clk.

Test Plan:
- Reset: assert rst for 2 cycles during T2 of an add -> next cycle state=T0, ir=0, bus_sel=0x001, rin=0, done=0; no T3 write occurs.
- mvi R2 then mv R5,R2: din=001_010_000 with run=1, then din=0x0A5.
  - T1 must show bus_sel=0x001, rin=0x04, done=1.
  - Next instruction din=000_101_010: T1 shows bus_sel=0x010, rin=0x20, done=1.
- add R1,R3 (din=010_001_011), run pulsed for one cycle:
  - T1: bus_sel=0x008, ain=1.
  - T2: bus_sel=0x020, gin=1, add_sub=0.
  - T3: bus_sel=0x002, rin=0x02, done=1.
  - Then idle in T0 with defaults.
- sub R7,R7 (din=011_111_111): T1 bus_sel=0x200, ain=1; T2 bus_sel=0x200, gin=1, add_sub=1; T3 rin=0x80, done=1.
- Reserved op 110_xxx_xxx: T1 has all enables 0 and done=1. Back-to-back run=1 shows a T0 irin cycle immediately after each done.
- run=0 for 10 cycles -> state stays T0, irin=0, ir unchanged. Assertion checks one-hot bus_sel and single-hot rin across a 1000-instruction random stream.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: control unit for the 9-bit multicycle CPU.
// Holds the instruction register and sequences each instruction over
// T0..T3, driving the datapath bus select and the load enables.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   run      in   start request, sampled only in T0
//   din      in   external data/instruction word (op[8:6], rx[5:3], ry[2:0])
//   bus_sel  out  one-hot bus select: bit0=DIN, bit1=G, bit2..9=R0..R7
//   rin      out  register load enables, bit n loads Rn
//   ain      out  load A from the bus
//   gin      out  load G from the ALU
//   add_sub  out  ALU op, 0=add 1=sub
//   irin     out  IR load strobe
//   ir       out  current instruction register (registered)
//   done     out  one-cycle completion pulse
module cpu_ctrl_fsm #(
    parameter int unsigned DW    = 9,
    parameter int unsigned SEL_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [DW-1:0]    din,
    output logic [SEL_W-1:0] bus_sel,
    output logic [7:0]       rin,
    output logic             ain,
    output logic             gin,
    output logic             add_sub,
    output logic             irin,
    output logic [DW-1:0]    ir,
    output logic             done
);

    localparam int unsigned NREG = 8;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam logic [SEL_W-1:0] SEL_DIN = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_G   = SEL_W'(2);
    // R0 sits at bit 2; register n is this value shifted left by n
    localparam logic [SEL_W-1:0] SEL_R0  = SEL_W'(4);

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;

    logic [2:0] op, rx, ry;

    assign op = ir_q[8:6];
    assign rx = ir_q[5:3];
    assign ry = ir_q[2:0];
    assign ir = ir_q;

    // Next-state and output decode
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        bus_sel = SEL_DIN;
        rin     = '0;
        ain     = 1'b0;
        gin     = 1'b0;
        add_sub = 1'b0;
        irin    = 1'b0;
        done    = 1'b0;

        case (state_q)
            T0: begin
                irin = run;
                if (run) begin
                    ir_d    = din;
                    state_d = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        bus_sel = SEL_R0 << ry;
                        rin     = NREG'(1) << rx;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_MVI: begin
                        // immediate is taken straight from din this cycle
                        rin     = NREG'(1) << rx;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        bus_sel = SEL_R0 << rx;
                        ain     = 1'b1;
                        state_d = T2;
                    end
                    default: begin
                        // reserved opcodes complete as a NOP
                        done    = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T2: begin
                bus_sel = SEL_R0 << ry;
                gin     = 1'b1;
                add_sub = (op == OP_SUB);
                state_d = T3;
            end
            T3: begin
                bus_sel = SEL_G;
                rin     = NREG'(1) << rx;
                done    = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

    // State and IR registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed and random checks of cpu_ctrl_fsm against a
// queue-based model that expands each instruction into its per-cycle
// output schedule.
module tb_cpu_ctrl_fsm;

    logic       clk;
    logic       rst;
    logic       run;
    logic [8:0] din;
    logic [9:0] bus_sel;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic       add_sub;
    logic       irin;
    logic [8:0] ir;
    logic       done;

    cpu_ctrl_fsm dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .din     (din),
        .bus_sel (bus_sel),
        .rin     (rin),
        .ain     (ain),
        .gin     (gin),
        .add_sub (add_sub),
        .irin    (irin),
        .ir      (ir),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] bs;
        logic [7:0] rin;
        logic       ain;
        logic       gin;
        logic       asub;
        logic       done;
    } step_t;

    step_t      want_q[$];
    logic [8:0] model_ir;
    int         n_checks;
    int         n_fail;
    int         n_instr;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, want);
        end
    endtask

    function automatic step_t mk(input logic [9:0] bs, input logic [7:0] r,
                                 input logic a, input logic g,
                                 input logic s, input logic d);
        step_t t;
        t.bs = bs; t.rin = r; t.ain = a; t.gin = g; t.asub = s; t.done = d;
        return t;
    endfunction

    // Expand one instruction into the outputs expected in T1.. onward
    task automatic issue(input logic [8:0] w);
        int op, rx, ry;
        op = int'(w[8:6]);
        rx = int'(w[5:3]);
        ry = int'(w[2:0]);
        case (op)
            0: want_q.push_back(mk(10'(1) << (2 + ry), 8'(1) << rx, 0, 0, 0, 1));
            1: want_q.push_back(mk(10'd1, 8'(1) << rx, 0, 0, 0, 1));
            2, 3: begin
                want_q.push_back(mk(10'(1) << (2 + rx), 8'd0, 1, 0, 0, 0));
                want_q.push_back(mk(10'(1) << (2 + ry), 8'd0, 0, 1, op == 3, 0));
                want_q.push_back(mk(10'd2, 8'(1) << rx, 0, 0, 0, 1));
            end
            default: want_q.push_back(mk(10'd1, 8'd0, 0, 0, 0, 1));
        endcase
    endtask

    // One clock: drive, check at negedge, advance model, cross posedge
    task automatic cyc(input logic r, input logic [8:0] d, input logic rs);
        step_t e;
        logic  e_irin;
        run = r; din = d; rst = rs;
        @(negedge clk);
        if (want_q.size() == 0) begin
            e      = mk(10'd1, 8'd0, 0, 0, 0, 0);
            e_irin = r;
        end else begin
            e      = want_q[0];
            e_irin = 1'b0;
        end
        check_val("bus_sel", 32'(bus_sel), 32'(e.bs));
        check_val("rin", 32'(rin), 32'(e.rin));
        check_val("ain", 32'(ain), 32'(e.ain));
        check_val("gin", 32'(gin), 32'(e.gin));
        check_val("add_sub", 32'(add_sub), 32'(e.asub));
        check_val("done", 32'(done), 32'(e.done));
        check_val("irin", 32'(irin), 32'(e_irin));
        check_val("ir", 32'(ir), 32'(model_ir));
        check_val("bus_onehot", 32'($countones(bus_sel)), 32'd1);
        check_val("rin_le1", 32'($countones(rin) <= 1), 32'd1);
        check_val("ain_gin_rin_excl",
                  32'(int'(ain) + int'(gin) + int'(rin != 0) <= 1), 32'd1);
        if (rs) begin
            want_q.delete();
            model_ir = 9'd0;
        end else if (want_q.size() == 0) begin
            if (r) begin
                model_ir = d;
                issue(d);
                n_instr++;
            end
        end else begin
            void'(want_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_cyc;
        n_checks = 0; n_fail = 0; n_instr = 0;
        model_ir = 9'd0;
        rst = 1'b1; run = 1'b0; din = 9'd0;
        @(posedge clk);
        #1;
        cyc(0, 9'd0, 1);
        cyc(0, 9'd0, 0);

        // Reset during T2 of add R1,R3: no T3 write afterwards
        cyc(1, 9'b010_001_011, 0);
        cyc(0, 9'd0, 0);
        cyc(0, 9'd0, 1);
        cyc(1, 9'd0, 1);
        cyc(0, 9'd0, 0);
        cyc(0, 9'd0, 0);

        // mvi R2, 0x0A5 then mv R5,R2 back-to-back
        cyc(1, 9'b001_010_000, 0);
        cyc(1, 9'h0A5, 0);
        cyc(1, 9'b000_101_010, 0);
        cyc(0, 9'd0, 0);
        cyc(0, 9'd0, 0);

        // add R1,R3 with a one-cycle run pulse
        cyc(1, 9'b010_001_011, 0);
        for (int i = 0; i < 4; i++) cyc(0, 9'h1FF, 0);

        // sub R7,R7
        cyc(1, 9'b011_111_111, 0);
        for (int i = 0; i < 4; i++) cyc(0, 9'd0, 0);

        // Reserved op back-to-back, run held high throughout
        for (int i = 0; i < 6; i++) cyc(1, 9'b110_101_011, 0);
        cyc(0, 9'd0, 0);
        cyc(0, 9'd0, 0);

        // Idle with run low: ir must hold
        for (int i = 0; i < 10; i++) cyc(0, 9'($urandom), 0);

        // Random stream of 1000 instructions with occasional resets
        n_instr = 0;
        n_cyc   = 0;
        while (n_instr < 1000 && n_cyc < 20000) begin
            cyc($urandom_range(0, 3) != 0, 9'($urandom),
                $urandom_range(0, 99) == 0);
            n_cyc++;
        end
        check_val("rand_budget", 32'(n_instr >= 1000), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
